// File: rtl/dt_pkg.sv
// Shared definitions for the decision-tree walker: node-word field widths,
// bit offsets, total node width and the walker state encoding.
package dt_pkg;

  localparam int FEAT_W_DEF      = 16;
  localparam int FEAT_IDX_W_DEF  = 6;
  localparam int NODE_ADDR_W_DEF = 10;
  localparam int CLASS_W_DEF     = 2;

  // Node word, MSB to LSB: leaf | class | feat_idx | threshold | left | right
  function automatic int node_w(int fw, int iw, int aw, int cw);
    return 1 + cw + iw + fw + 2 * aw;
  endfunction

  function automatic int left_lsb(int aw);
    return aw;
  endfunction

  function automatic int thr_lsb(int aw);
    return 2 * aw;
  endfunction

  function automatic int idx_lsb(int fw, int aw);
    return 2 * aw + fw;
  endfunction

  function automatic int class_lsb(int fw, int iw, int aw);
    return 2 * aw + fw + iw;
  endfunction

  function automatic int leaf_pos(int fw, int iw, int aw, int cw);
    return 2 * aw + fw + iw + cw;
  endfunction

  localparam int NODE_W_DEF = node_w(FEAT_W_DEF, FEAT_IDX_W_DEF, NODE_ADDR_W_DEF, CLASS_W_DEF);

  typedef enum logic [2:0] {
    IDLE,
    NODE_REQ,
    NODE_CAP,
    FEAT_REQ,
    FEAT_CAP,
    DONE
  } dt_state_e;

endpackage

// File: rtl/dt_node_unpack.sv
// Purely combinational split of a node-memory word into its named fields.
// Also used by the tree-loader checker, so keep it free of state.
module dt_node_unpack
  import dt_pkg::*;
#(
  parameter int FEAT_W      = FEAT_W_DEF,
  parameter int FEAT_IDX_W  = FEAT_IDX_W_DEF,
  parameter int NODE_ADDR_W = NODE_ADDR_W_DEF,
  parameter int CLASS_W     = CLASS_W_DEF,
  localparam int NODE_W     = node_w(FEAT_W, FEAT_IDX_W, NODE_ADDR_W, CLASS_W)
) (
  input  logic [NODE_W-1:0]      node_i,
  output logic                   leaf_o,
  output logic [CLASS_W-1:0]     class_o,
  output logic [FEAT_IDX_W-1:0]  feat_idx_o,
  output logic [FEAT_W-1:0]      thr_o,
  output logic [NODE_ADDR_W-1:0] left_o,
  output logic [NODE_ADDR_W-1:0] right_o
);

  assign leaf_o     = node_i[leaf_pos(FEAT_W, FEAT_IDX_W, NODE_ADDR_W, CLASS_W)];
  assign class_o    = node_i[class_lsb(FEAT_W, FEAT_IDX_W, NODE_ADDR_W) +: CLASS_W];
  assign feat_idx_o = node_i[idx_lsb(FEAT_W, NODE_ADDR_W) +: FEAT_IDX_W];
  assign thr_o      = node_i[thr_lsb(NODE_ADDR_W) +: FEAT_W];
  assign left_o     = node_i[left_lsb(NODE_ADDR_W) +: NODE_ADDR_W];
  assign right_o    = node_i[0 +: NODE_ADDR_W];

endmodule

// File: rtl/dt_tree_walker.sv
// Walks the decision tree in node memory from the root to a leaf and reports
// the predicted class. Define DT_SIGNED_CMP_EN for signed feature/threshold compare.
module dt_tree_walker
  import dt_pkg::*;
#(
  parameter int FEAT_W      = FEAT_W_DEF,
  parameter int FEAT_IDX_W  = FEAT_IDX_W_DEF,
  parameter int NODE_ADDR_W = NODE_ADDR_W_DEF,
  parameter int CLASS_W     = CLASS_W_DEF,
  parameter int ROOT_ADDR   = 0,
  parameter int MAX_DEPTH   = 32,
  localparam int NODE_W     = node_w(FEAT_W, FEAT_IDX_W, NODE_ADDR_W, CLASS_W),
  localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   node_rd_en,
  output logic [NODE_ADDR_W-1:0] node_addr,
  input  logic [NODE_W-1:0]      node_rdata,
  output logic                   feat_rd_en,
  output logic [FEAT_IDX_W-1:0]  feat_addr,
  input  logic [FEAT_W-1:0]      feat_rdata,
  output logic [CLASS_W-1:0]     class_out,
  output logic                   class_valid,
  output logic                   depth_err
);

  dt_state_e              state_q, state_d;
  logic                   start_q;
  logic [NODE_ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [DEPTH_W-1:0]     depth_q, depth_d;
  logic [FEAT_IDX_W-1:0]  feat_idx_q, feat_idx_d;
  logic [FEAT_W-1:0]      thr_q, thr_d;
  logic [NODE_ADDR_W-1:0] left_q, left_d, right_q, right_d;
  logic [CLASS_W-1:0]     class_q, class_d;
  logic                   err_q, err_d;

  logic                   n_leaf;
  logic [CLASS_W-1:0]     n_class;
  logic [FEAT_IDX_W-1:0]  n_idx;
  logic [FEAT_W-1:0]      n_thr;
  logic [NODE_ADDR_W-1:0] n_left, n_right;
  logic                   go_left;

  dt_node_unpack #(
    .FEAT_W      (FEAT_W),
    .FEAT_IDX_W  (FEAT_IDX_W),
    .NODE_ADDR_W (NODE_ADDR_W),
    .CLASS_W     (CLASS_W)
  ) u_unpack (
    .node_i     (node_rdata),
    .leaf_o     (n_leaf),
    .class_o    (n_class),
    .feat_idx_o (n_idx),
    .thr_o      (n_thr),
    .left_o     (n_left),
    .right_o    (n_right)
  );

  // Equality goes left in both compare modes.
`ifdef DT_SIGNED_CMP_EN
  assign go_left = $signed(feat_rdata) <= $signed(thr_q);
`else
  assign go_left = feat_rdata <= thr_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from the same clock edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      cur_addr_q <= '0;
      depth_q    <= '0;
      feat_idx_q <= '0;
      thr_q      <= '0;
      left_q     <= '0;
      right_q    <= '0;
      class_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      cur_addr_q <= cur_addr_d;
      depth_q    <= depth_d;
      feat_idx_q <= feat_idx_d;
      thr_q      <= thr_d;
      left_q     <= left_d;
      right_q    <= right_d;
      class_q    <= class_d;
      err_q      <= err_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    depth_d    = depth_q;
    feat_idx_d = feat_idx_q;
    thr_d      = thr_q;
    left_d     = left_q;
    right_d    = right_q;
    class_d    = class_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (start && !start_q) begin
          cur_addr_d = NODE_ADDR_W'(ROOT_ADDR);
          depth_d    = '0;
          class_d    = '0;
          err_d      = 1'b0;
          state_d    = NODE_REQ;
        end
      end
      NODE_REQ: state_d = NODE_CAP;
      NODE_CAP: begin
        feat_idx_d = n_idx;
        thr_d      = n_thr;
        left_d     = n_left;
        right_d    = n_right;
        if (n_leaf) begin
          class_d = n_class;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = FEAT_REQ;
        end
      end
      FEAT_REQ: state_d = FEAT_CAP;
      FEAT_CAP: begin
        // depth_q < MAX_DEPTH here, so the increment cannot wrap
        cur_addr_d = go_left ? left_q : right_q;
        depth_d    = depth_q + DEPTH_W'(1);
        state_d    = NODE_REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == NODE_REQ) || (state_q == NODE_CAP) ||
                       (state_q == FEAT_REQ) || (state_q == FEAT_CAP);
  assign node_rd_en  = (state_q == NODE_REQ);
  assign node_addr   = node_rd_en ? cur_addr_q : '0;
  assign feat_rd_en  = (state_q == FEAT_REQ);
  assign feat_addr   = feat_rd_en ? feat_idx_q : '0;
  assign class_valid = (state_q == DONE);
  assign class_out   = class_q;
  assign depth_err   = err_q;

endmodule
